// File: rtl/fft_pkg.sv
// rtl/fft_pkg.sv - shared defaults, FSM state type and power-width helper for fft_peak_detect
package fft_pkg;

  localparam int DATA_W_DEF    = 14;
  localparam int NFFT_LOG2_DEF = 9;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FLUSH,
    REPORT
  } state_t;

  // re^2 + im^2 of two DATA_W-bit signed values needs one bit more than a single square
  function automatic int pwr_w(input int data_w);
    return 2 * data_w + 1;
  endfunction

endpackage

// File: rtl/fft_pwr_calc.sv
// rtl/fft_pwr_calc.sv - two-stage re^2 + im^2 pipeline with valid/idx/last sideband
module fft_pwr_calc
  import fft_pkg::*;
#(
  parameter int DATA_W = DATA_W_DEF,
  parameter int IDX_W  = NFFT_LOG2_DEF
) (
  input  logic                       SCLK,
  input  logic                       rst_n,
  input  logic                       in_valid,
  input  logic signed [DATA_W-1:0]   in_re,
  input  logic signed [DATA_W-1:0]   in_im,
  input  logic [IDX_W-1:0]           in_idx,
  input  logic                       in_last,
  output logic                       out_valid,
  output logic [pwr_w(DATA_W)-1:0]   out_pwr,
  output logic [IDX_W-1:0]           out_idx,
  output logic                       out_last
);

  logic signed [2*DATA_W-1:0] re_x;
  logic signed [2*DATA_W-1:0] im_x;
  logic [2*DATA_W-1:0]        re_sq;
  logic [2*DATA_W-1:0]        im_sq;
  logic [IDX_W-1:0]           s1_idx;
  logic                       s1_valid;
  logic                       s1_last;

  assign re_x = {{DATA_W{in_re[DATA_W-1]}}, in_re};
  assign im_x = {{DATA_W{in_im[DATA_W-1]}}, in_im};

  // data registers only load on valid beats; valid/last always advance so gaps stay empty
  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      s1_valid  <= 1'b0;
      s1_last   <= 1'b0;
      s1_idx    <= '0;
      re_sq     <= '0;
      im_sq     <= '0;
      out_valid <= 1'b0;
      out_last  <= 1'b0;
      out_idx   <= '0;
      out_pwr   <= '0;
    end else begin
      s1_valid  <= in_valid;
      s1_last   <= in_valid & in_last;
      out_valid <= s1_valid;
      out_last  <= s1_last;
      if (in_valid) begin
        s1_idx <= in_idx;
        re_sq  <= re_x * re_x;
        im_sq  <= im_x * im_x;
      end
      if (s1_valid) begin
        out_idx <= s1_idx;
        out_pwr <= {1'b0, re_sq} + {1'b0, im_sq};
      end
    end
  end

endmodule

// File: rtl/fft_peak_detect.sv
// rtl/fft_peak_detect.sv - per-frame spectral peak finder with frame-length check
// Optional: define FFT_PEAK_SKIP_DC_EN to exclude bin 0 from the peak search.
module fft_peak_detect
  import fft_pkg::*;
#(
  parameter int DATA_W        = DATA_W_DEF,
  parameter int NFFT_LOG2     = NFFT_LOG2_DEF,
  parameter bit HALF_SPECTRUM = 1'b1
) (
  input  logic                       SCLK,
  input  logic                       rst_n,
  input  logic [31:0]                s_axis_data_tdata,
  input  logic                       s_axis_data_tvalid,
  output logic                       s_axis_data_tready,
  input  logic                       s_axis_data_tlast,
  output logic                       peak_valid,
  output logic [NFFT_LOG2-1:0]       peak_idx,
  output logic [pwr_w(DATA_W)-1:0]   peak_pwr,
  output logic                       frame_err,
  output logic [15:0]                frame_cnt
);

  localparam int                   PWR_W    = pwr_w(DATA_W);
  localparam logic [NFFT_LOG2-1:0] LAST_BIN = '1;

  state_t               state;
  logic [NFFT_LOG2-1:0] bin_cnt;
  logic [NFFT_LOG2-1:0] s2_idx;
  logic [NFFT_LOG2-1:0] max_idx;
  logic [NFFT_LOG2-1:0] nxt_idx;
  logic [PWR_W-1:0]     s2_pwr;
  logic [PWR_W-1:0]     max_pwr;
  logic [PWR_W-1:0]     nxt_pwr;
  logic                 accept;
  logic                 end_beat;
  logic                 s2_valid;
  logic                 s2_last;
  logic                 s2_elig;
  logic                 len_err;
  logic                 unused_tdata_hi;

  assign accept          = s_axis_data_tvalid & s_axis_data_tready;
  assign end_beat        = s_axis_data_tlast | (bin_cnt == LAST_BIN);
  assign unused_tdata_hi = ^s_axis_data_tdata[31:2*DATA_W];

  fft_pwr_calc #(
    .DATA_W (DATA_W),
    .IDX_W  (NFFT_LOG2)
  ) u_pwr (
    .SCLK      (SCLK),
    .rst_n     (rst_n),
    .in_valid  (accept),
    .in_re     (s_axis_data_tdata[DATA_W-1:0]),
    .in_im     (s_axis_data_tdata[2*DATA_W-1:DATA_W]),
    .in_idx    (bin_cnt),
    .in_last   (end_beat),
    .out_valid (s2_valid),
    .out_pwr   (s2_pwr),
    .out_idx   (s2_idx),
    .out_last  (s2_last)
  );

  // upper half of the spectrum is the index MSB set
  always_comb begin
    s2_elig = s2_valid;
    if (HALF_SPECTRUM && s2_idx[NFFT_LOG2-1]) s2_elig = 1'b0;
`ifdef FFT_PEAK_SKIP_DC_EN
    if (s2_idx == '0) s2_elig = 1'b0;
`endif
  end

  // strict compare keeps the lowest index on ties
  always_comb begin
    nxt_idx = max_idx;
    nxt_pwr = max_pwr;
    if (s2_elig && (s2_pwr > max_pwr)) begin
      nxt_idx = s2_idx;
      nxt_pwr = s2_pwr;
    end
  end

  always_ff @(posedge SCLK or negedge rst_n) begin
    if (!rst_n) begin
      state              <= IDLE;
      s_axis_data_tready <= 1'b0;
      bin_cnt            <= '0;
      len_err            <= 1'b0;
      max_idx            <= '0;
      max_pwr            <= '0;
      peak_valid         <= 1'b0;
      peak_idx           <= '0;
      peak_pwr           <= '0;
      frame_err          <= 1'b0;
      frame_cnt          <= '0;
    end else begin
      peak_valid <= 1'b0;
      frame_err  <= 1'b0;
      max_idx    <= nxt_idx;
      max_pwr    <= nxt_pwr;
      case (state)
        IDLE, RUN: begin
          s_axis_data_tready <= 1'b1;
          if (accept) begin
            if (end_beat) begin
              state              <= FLUSH;
              s_axis_data_tready <= 1'b0;
              bin_cnt            <= '0;
              len_err            <= s_axis_data_tlast ^ (bin_cnt == LAST_BIN);
            end else begin
              state   <= RUN;
              bin_cnt <= bin_cnt + 1'b1;
            end
          end
        end
        // the frame's last beat leaves the pipeline two cycles after acceptance
        FLUSH: begin
          if (s2_last) begin
            state      <= REPORT;
            peak_valid <= 1'b1;
            peak_idx   <= nxt_idx;
            peak_pwr   <= nxt_pwr;
            frame_err  <= len_err;
            frame_cnt  <= frame_cnt + 1'b1;
          end
        end
        REPORT: begin
          state              <= IDLE;
          s_axis_data_tready <= 1'b1;
          max_idx            <= '0;
          max_pwr            <= '0;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule

// File: doc/fft_peak_detect.md
Name: fft_peak_detect

Overview:
- AXI-Stream sink that sits on the FFT core's output (m_axis_data) and consumes one complex spectrum frame at a time.
- Computes per-bin power re²+im² in a 2-stage pipeline and tracks the strongest bin.
- At frame end, reports peak bin index and power for the downstream tone-detect/display logic.
- Flags frames whose tlast does not match the configured transform length.

Parameters:
- DATA_W, 14, width of each signed real/imag component.
- NFFT_LOG2, 9, log2 of transform length (N = 512, matching FFT config NFFT=5'b01001).
- HALF_SPECTRUM, 1, 1 = only bins 0..N/2-1 compete for peak; 0 = all N bins.

Ports:
- SCLK  in  1  system clock, all logic on rising edge.
- rst_n  in  1  asynchronous active-low reset.
- s_axis_data_tdata  in  32  re = [DATA_W-1:0], im = [2*DATA_W-1:DATA_W], both two's complement; upper bits ignored.
- s_axis_data_tvalid  in  1  beat valid.
- s_axis_data_tready  out  1  sink ready.
- s_axis_data_tlast  in  1  last beat of frame.
- peak_valid  out  1  one-cycle pulse; peak_idx/peak_pwr valid.
- peak_idx  out  NFFT_LOG2  bin index of maximum power.
- peak_pwr  out  2*DATA_W+1  power of peak bin (unsigned).
- frame_err  out  1  one-cycle pulse alongside peak_valid when frame length ≠ N.
- frame_cnt  out  16  count of reported frames, wraps at 65535→0.

Behaviour:
- Reset (async assert, sync release): state=IDLE, tready=0 during reset then 1, peak_valid=0, peak_idx=0, peak_pwr=0, frame_err=0, frame_cnt=0, bin counter=0, running max=0.
- Beat accepted when tvalid & tready. Bin index = internal counter, 0 at frame start, +1 per accepted beat.
- Power pipeline:
  - stage 1 registers re², im² (signed multiply, 2*DATA_W bits).
  - stage 2 registers sum (2*DATA_W+1 bits, no saturation).
  - Index and eligibility travel alongside.
- Peak update: eligible bin replaces max when pwr > max (strict; ties keep lowest index). Eligible = index < N/2 when HALF_SPECTRUM=1, else all.
- Running max cleared to 0 / idx 0 at frame start; a frame of all zeros reports idx 0, pwr 0.
- States:
  - IDLE: tready=1; first accepted beat → RUN.
  - RUN: tready=1; beat with tlast, or beat with counter=N-1 → FLUSH.
  - FLUSH: tready=0, 2 cycles to drain pipeline → REPORT.
  - REPORT: tready=0, peak_valid=1 for one cycle, frame_cnt++ → IDLE.
- Latency: final beat accepted on cycle T → peak_valid high on cycle T+3. Next frame beat accepted at T+4 at the earliest.
- Length errors:
  - tlast at counter≠N-1 → frame ends early, frame_err=1 in REPORT.
  - counter=N-1 without tlast → frame ends, frame_err=1.
  - Either way the peak is still reported.
- tvalid low mid-frame: pipeline holds no bubble data (eligibility qualified by accept); counter holds.
- peak_idx/peak_pwr hold their value until the next REPORT.
- Single-beat frame (tlast on bin 0): legal, frame_err=1, reports bin 0.

Optional Feature:
- FFT_PEAK_SKIP_DC_EN defined: bin 0 is never eligible. A frame where no eligible bin exceeds 0 reports idx 0, pwr 0.
- Undefined: bin 0 competes normally.

Decomposition:
- Package fft_pkg: DATA_W, NFFT_LOG2 defaults, state enum (IDLE/RUN/FLUSH/REPORT), function for power width.
- Sub-module fft_pwr_calc: 2-stage re²+im² pipeline with valid/idx/last sideband.
- Top holds FSM, counter and comparator.

Test Plan:
- Single tone: 512 beats, bin 37 = (re=1000, im=0), all others (10, 10), tlast on beat 511 → peak_idx=37, peak_pwr=1000000, frame_err=0, peak_valid exactly 3 cycles after last beat.
- Tie and half-spectrum: bins 20 and 300 both (−8192, −8192), others 0 → idx 20, pwr 134217728. With HALF_SPECTRUM=0, bins 20 and 300 at 500 and 600 → idx 300.
- Short frame: tlast on beat 99, peak at bin 50 = (0, 200) → idx 50, pwr 40000, frame_err=1. Missing tlast on a 512-beat frame → frame_err=1.
- Backpressure: random tvalid gaps at 50% across two back-to-back frames → correct peaks for both, frame_cnt=2, tready low for exactly 3 cycles after each last beat.
- Reset mid-frame: assert rst_n=0 at beat 200, release, send a full frame → outputs zero during reset, only the post-reset frame is reported, frame_cnt=1.
- DC: bin 0 = 5000, bin 3 = 100 → idx 0 by default; with FFT_PEAK_SKIP_DC_EN defined → idx 3, pwr 10000.
